player_physics_y: RTL and testbench

- Parametrised successor of the single-player vertical controller.
- Integrates signed vertical velocity under gravity once per tick.
- Supports multi-jump, fast-drop, ceiling/ground clamping and platform landing via a latency-tolerant probe of the terrain bitmap ROM.
- Sits between the keyboard decoder (key codes from vga_pkg) and the sprite/draw pipeline; drives player_ypos and the terrain ROM address.

---
 rtl/player_physics_y.sv | 233 +++++++++++++++++++++++
 tb/tb_player_physics_y.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/player_physics_y.sv
// player_physics_y: vertical player physics. Once per tick the signed velocity
// is integrated under gravity with multi-jump, fast-drop, ceiling/floor
// clamping and platform landing via a probe of the terrain bitmap ROM.
module player_physics_y #(
    parameter int unsigned TICK_CYCLES = 2000000,
    parameter int unsigned Y_W         = 8,
    parameter int unsigned V_W         = 6,
    parameter int unsigned Y_GROUND    = 192,
    parameter int unsigned Y_CEIL      = 0,
    parameter int unsigned JUMP_V      = 12,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned MAX_FALL    = 8,
    parameter int unsigned MAX_JUMPS   = 2,
    parameter int unsigned MAP_LAT     = 1,
    parameter int unsigned SCALE       = 2,
    parameter int unsigned MAP_OFS     = 16,
    parameter logic [11:0] SOLID_RGB   = 12'h000,
    // key codes; defaults must match key_W / key_S of the keyboard decoder
    parameter logic [3:0]  KEY_W       = 4'h1,
    parameter logic [3:0]  KEY_S       = 4'h2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     key,
    input  logic [9:0]     xpos,
    input  logic [11:0]    rgb_pixel,
    output logic [13:0]    map_adr,
    output logic [Y_W-1:0] player_ypos,
    output logic           grounded,
    output logic           tick_done
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned JMP_W = $clog2(MAX_JUMPS + 1);
    localparam int unsigned LAT_W = $clog2(MAP_LAT + 1);
    localparam int unsigned SW    = Y_W + 2;
    localparam int unsigned VX    = V_W + 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [Y_W-1:0]        GROUND_Y  = Y_W'(Y_GROUND);
    localparam logic signed [SW-1:0]  GROUND_S  = SW'(Y_GROUND);
    localparam logic signed [SW-1:0]  CEIL_S    = SW'(Y_CEIL);
    localparam logic signed [V_W-1:0] JUMP_VN   = V_W'(0 - JUMP_V);
    localparam logic signed [VX-1:0]  MAXF_X    = VX'(MAX_FALL);
    localparam logic signed [VX-1:0]  G1_X      = VX'(GRAVITY);
    localparam logic signed [VX-1:0]  G2_X      = VX'(2 * GRAVITY);
    localparam logic [JMP_W-1:0]      JMP_MAX   = JMP_W'(MAX_JUMPS);
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(MAP_LAT);
    localparam logic [Y_W-1:0]        MAP_OFS_Y = Y_W'(MAP_OFS);
    localparam logic [9:0]            MAP_OFS_X = 10'(MAP_OFS);

    typedef enum logic [2:0] {
        WAIT_TICK,
        CALC,
        PROBE,
        WAIT_ROM,
        COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [3:0]            key_prev_q, key_prev_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] vel_q, vel_d;
    logic                  gnd_q, gnd_d;
    logic [JMP_W-1:0]      jmp_q, jmp_d;
    // update in flight, copied to the architectural state in COMMIT
    logic [Y_W-1:0]        yn_q, yn_d;
    logic signed [V_W-1:0] veln_q, veln_d;
    logic                  gndn_q, gndn_d;
    logic [JMP_W-1:0]      jmpn_q, jmpn_d;
    logic [13:0]           map_adr_q, map_adr_d;
    logic [LAT_W-1:0]      lat_q, lat_d;

    logic                  jump_req;
    logic                  walk;
    logic signed [VX-1:0]  vsum;
    logic signed [V_W-1:0] vel_c;
    logic signed [SW-1:0]  sum_s;
    logic [Y_W-1:0]        cand_c;
    logic [Y_W-1:0]        probe_y;

    assign map_adr     = map_adr_q;
    assign player_ypos = y_q;
    assign grounded    = gnd_q;
    assign tick_done   = (state_q == COMMIT);

    // Free-running tick divider; a tick landing outside WAIT_TICK stays pending (one deep).
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        pend_d = (cnt_q == CNT_LAST) | (pend_q & (state_q != WAIT_TICK));
    end

    // Physics FSM: next state, velocity integration, clamping and probe handling.
    always_comb begin
        state_d    = state_q;
        key_prev_d = key_prev_q;
        y_d        = y_q;
        vel_d      = vel_q;
        gnd_d      = gnd_q;
        jmp_d      = jmp_q;
        yn_d       = yn_q;
        veln_d     = veln_q;
        gndn_d     = gndn_q;
        jmpn_d     = jmpn_q;
        map_adr_d  = map_adr_q;
        lat_d      = lat_q;
        jump_req   = 1'b0;
        walk       = 1'b0;
        vsum       = '0;
        vel_c      = '0;
        sum_s      = '0;
        cand_c     = y_q;
        probe_y    = y_q;

        unique case (state_q)
            WAIT_TICK: begin
                if (pend_q) state_d = CALC;
            end
            CALC: begin
                key_prev_d = key;
                jump_req   = (key == KEY_W) && (key_prev_q != KEY_W) && (jmp_q != '0);
                gndn_d     = gnd_q;
                jmpn_d     = jmp_q;
                if (jump_req) begin
                    vel_c  = JUMP_VN;
                    jmpn_d = jmp_q - 1'b1;
                    gndn_d = 1'b0;
                end else if (!gnd_q) begin
                    vsum = $signed({vel_q[V_W-1], vel_q}) + ((key == KEY_S) ? G2_X : G1_X);
                    vel_c = (vsum > MAXF_X) ? MAXF_X[V_W-1:0] : vsum[V_W-1:0];
                end else begin
                    vel_c = '0;
                end

                sum_s = $signed({2'b00, y_q}) + $signed({{(SW - V_W){vel_c[V_W-1]}}, vel_c});
                if (sum_s < CEIL_S) begin
                    cand_c = CEIL_S[Y_W-1:0];
                    vel_c  = '0;
                end else if (sum_s > GROUND_S) begin
                    cand_c = GROUND_Y;
                end else begin
                    cand_c = sum_s[Y_W-1:0];
                end

                // resting on a platform: probe the row just below to detect walking off
                walk    = gnd_q && !jump_req;
                probe_y = walk ? cand_c + 1'b1 : cand_c;
                yn_d    = cand_c;

                if ((cand_c == GROUND_Y) && !vel_c[V_W-1]) begin
                    gndn_d  = 1'b1;
                    veln_d  = '0;
                    jmpn_d  = JMP_MAX;
                    state_d = COMMIT;
                end else begin
                    veln_d = vel_c;
                    if ((!vel_c[V_W-1] && (vel_c != '0)) || walk) begin
                        // address registered on entry so the ROM sees it during PROBE
                        map_adr_d[13:8] = 6'((probe_y >> SCALE) + MAP_OFS_Y);
                        map_adr_d[7:0]  = 8'((xpos >> SCALE) + MAP_OFS_X);
                        state_d         = PROBE;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            PROBE: begin
                lat_d   = LAT_LOAD;
                state_d = WAIT_ROM;
            end
            WAIT_ROM: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LAT_W'(1)) begin
                    if (rgb_pixel != SOLID_RGB) begin
                        yn_d   = y_q;
                        veln_d = '0;
                        gndn_d = 1'b1;
                        jmpn_d = JMP_MAX;
                    end else begin
                        gndn_d = 1'b0;
                    end
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                y_d     = yn_q;
                vel_d   = veln_q;
                gnd_d   = gndn_q;
                jmp_d   = jmpn_q;
                state_d = WAIT_TICK;
            end
            default: state_d = WAIT_TICK;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_TICK;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            key_prev_q <= '0;
            y_q        <= GROUND_Y;
            vel_q      <= '0;
            gnd_q      <= 1'b1;
            jmp_q      <= JMP_MAX;
            yn_q       <= GROUND_Y;
            veln_q     <= '0;
            gndn_q     <= 1'b1;
            jmpn_q     <= JMP_MAX;
            map_adr_q  <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            key_prev_q <= key_prev_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            gnd_q      <= gnd_d;
            jmp_q      <= jmp_d;
            yn_q       <= yn_d;
            veln_q     <= veln_d;
            gndn_q     <= gndn_d;
            jmpn_q     <= jmpn_d;
            map_adr_q  <= map_adr_d;
            lat_q      <= lat_d;
        end
    end

endmodule

// File: tb/tb_player_physics_y.sv
// tb_player_physics_y: directed tick-by-tick trajectories against three
// configurations (baseline, low ceiling, 3-cycle ROM latency).
module tb_player_physics_y;

    localparam logic [3:0] K_W = 4'h1;
    localparam logic [3:0] K_S = 4'h2;
    localparam logic [3:0] K_0 = 4'h0;

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [3:0]  key;
    logic [9:0]  xpos;
    logic        plat_en;

    logic [11:0] rgb0, rgb1, rgb2, s2a, s2b;
    logic [13:0] adr0, adr1, adr2;
    logic [7:0]  y0, y1, y2;
    logic        g0, g1, g2, d0, d1, d2;

    logic [13:0] adr_a [3];
    logic [7:0]  y_a   [3];
    logic        g_a   [3];
    logic        d_a   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign adr_a[0] = adr0; assign adr_a[1] = adr1; assign adr_a[2] = adr2;
    assign y_a[0]   = y0;   assign y_a[1]   = y1;   assign y_a[2]   = y2;
    assign g_a[0]   = g0;   assign g_a[1]   = g1;   assign g_a[2]   = g2;
    assign d_a[0]   = d0;   assign d_a[1]   = d1;   assign d_a[2]   = d2;

    player_physics_y #(.TICK_CYCLES(4), .MAP_LAT(1), .KEY_W(K_W), .KEY_S(K_S)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .key(key), .xpos(xpos), .rgb_pixel(rgb0),
        .map_adr(adr0), .player_ypos(y0), .grounded(g0), .tick_done(d0));

    player_physics_y #(.TICK_CYCLES(4), .Y_CEIL(150), .KEY_W(K_W), .KEY_S(K_S)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .key(key), .xpos(xpos), .rgb_pixel(rgb1),
        .map_adr(adr1), .player_ypos(y1), .grounded(g1), .tick_done(d1));

    player_physics_y #(.TICK_CYCLES(4), .MAP_LAT(3), .KEY_W(K_W), .KEY_S(K_S)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .key(key), .xpos(xpos), .rgb_pixel(rgb2),
        .map_adr(adr2), .player_ypos(y2), .grounded(g2), .tick_done(d2));

    // terrain: address 0 solid (stale-read trap), optional solid map row 58
    function automatic logic [11:0] map_pix(input logic [13:0] a, input logic plat);
        return ((a == 14'd0) || (plat && (a[13:8] == 6'd58))) ? 12'hFFF : 12'h000;
    endfunction

    // ROM models: 1-cycle for dut0/dut1, 3-cycle pipeline for dut2
    always @(posedge clk) begin
        rgb0 <= map_pix(adr0, plat_en);
        rgb1 <= map_pix(adr1, 1'b0);
        s2a  <= map_pix(adr2, 1'b0);
        s2b  <= s2a;
        rgb2 <= s2b;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive key, wait for tick_done of dut d, return with outputs committed
    task automatic step(input int d, input logic [3:0] k, output int cyc);
        key = k;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!d_a[d] && cyc < 300);
        if (!d_a[d]) check_val("tick_timeout", cyc, -1);
        @(negedge clk);
    endtask

    task automatic do_reset(input int d);
        rst_v[d] = 1'b1;
        repeat (2) @(negedge clk);
        rst_v[d] = 1'b0;
    endtask

    task automatic check_reset(input int d, input string tag);
        check_val({tag, "_y"}, int'(y_a[d]), 192);
        check_val({tag, "_gnd"}, int'(g_a[d]), 1);
        check_val({tag, "_done"}, int'(d_a[d]), 0);
        check_val({tag, "_adr"}, int'(adr_a[d]), 0);
    endtask

    int cyc;
    int exp_hold_y [28] = '{180, 169, 159, 150, 142, 135, 129, 124, 120, 117, 115, 114, 114, 115,
                            117, 120, 124, 129, 135, 142, 150, 158, 166, 174, 182, 190, 192, 192};
    logic [3:0] dj_key [6] = '{K_W, K_0, K_W, K_W, K_0, K_W};
    int         dj_y   [6] = '{180, 169, 157, 146, 136, 127};
    int plat_y [23] = '{180, 169, 159, 150, 142, 135, 129, 124, 120, 117, 115, 114, 114, 115,
                        118, 123, 130, 138, 146, 154, 162, 162, 150};
    int ceil_y [8]  = '{180, 169, 159, 150, 150, 151, 153, 156};
    int fd_y   [12] = '{180, 170, 162, 156, 152, 150, 150, 152, 156, 162, 170, 178};

    initial begin
        rst_v   = 3'b111;
        key     = K_0;
        xpos    = 10'd100;
        plat_en = 1'b0;
        repeat (3) @(negedge clk);

        // baseline: W held from rest, full flight and landing
        rst_v[0] = 1'b0;
        check_reset(0, "rst0");
        for (int t = 1; t <= 28; t++) begin
            step(0, K_W, cyc);
            if (t == 1) check_val("first_tick_lat", cyc, 6);
            check_val($sformatf("hold_y_t%0d", t), int'(y0), exp_hold_y[t-1]);
            check_val($sformatf("hold_gnd_t%0d", t), int'(g0), (t >= 27) ? 1 : 0);
        end

        // double jump; third press ignored
        do_reset(0);
        for (int t = 1; t <= 6; t++) begin
            step(0, dj_key[t-1], cyc);
            check_val($sformatf("dj_y_t%0d", t), int'(y0), dj_y[t-1]);
            check_val($sformatf("dj_gnd_t%0d", t), int'(g0), 0);
        end

        // platform landing at cand=170 (map row 58), then jump from it
        do_reset(0);
        plat_en = 1'b1;
        for (int t = 1; t <= 23; t++) begin
            step(0, (t == 1 || t == 23) ? K_W : ((t >= 15) ? K_S : K_0), cyc);
            check_val($sformatf("plat_y_t%0d", t), int'(y0), plat_y[t-1]);
            check_val($sformatf("plat_gnd_t%0d", t), int'(g0), (t == 22) ? 1 : 0);
            if (t == 22) check_val("plat_adr", int'(adr0), 14889);
        end
        plat_en  = 1'b0;
        rst_v[0] = 1'b1;

        // low ceiling at 150
        do_reset(1);
        check_reset(1, "rst1");
        for (int t = 1; t <= 8; t++) begin
            step(1, (t == 1) ? K_W : K_0, cyc);
            check_val($sformatf("ceil_y_t%0d", t), int'(y1), ceil_y[t-1]);
        end
        rst_v[1] = 1'b1;

        // 3-cycle ROM latency with fast-drop
        do_reset(2);
        for (int t = 1; t <= 12; t++) begin
            step(2, (t == 1) ? K_W : K_S, cyc);
            if (t == 1) check_val("lat3_first_tick", cyc, 6);
            if (t == 8) begin
                check_val("lat3_probe_lat", cyc, 7);
                check_val("lat3_adr", int'(adr2), 13865);
            end
            check_val($sformatf("fd_y_t%0d", t), int'(y2), fd_y[t-1]);
        end

        // reset while waiting on the ROM
        begin
            logic [13:0] prev;
            int n;
            prev = adr2;
            n = 0;
            while (adr2 == prev && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_val("probe_seen", int'(adr2 != prev), 1);
            @(negedge clk);
            rst_v[2] = 1'b1;
            @(negedge clk);
            check_reset(2, "midrst");
            rst_v[2] = 1'b0;
            step(2, K_S, cyc);
            check_val("post_rst_lat", cyc, 6);
            check_val("post_rst_y", int'(y2), 192);
            check_val("post_rst_gnd", int'(g2), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
